load_store_unit: RTL

Load/store unit that sits directly upstream of the data memory (`Memory_Unit`) in the MIPS datapath, between the EX/MEM pipeline register and the memory port. It accepts one byte, halfword or word request at a time and drives the word-wide `address`/`MemRead`/`MemWrite`/`write_data` port of the memory. Sub-word stores are done by read-modify-write, because the memory has no byte enables. Load data is returned sign- or zero-extended.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and word-memory port bundle for load_store_unit.
// slave = the unit's view, master = requester plus memory side.
interface load_store_unit_if #(parameter int ADDR_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_write_data;
  logic [31:0]           mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_read, mem_write, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_read, mem_write, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a word-only memory; sub-word
// stores use read-modify-write. Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  write_q;
  logic                  uns_q;
  logic [31:0]           wdata_q;
  logic [31:0]           mwdata_q;
  logic [31:0]           rdata_q;
  logic                  req_fault;
  logic                  accept;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [31:0]           load_val;
  logic [31:0]           merged;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign req_fault = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
  assign bus.resp_error = err_q && (state == RESP);
`else
  assign req_fault      = 1'b0;
  assign bus.resp_error = 1'b0;
`endif

  assign accept             = bus.req_valid && (state == IDLE);
  assign bus.req_ready      = (state == IDLE);
  assign bus.mem_read       = (state == READ);
  assign bus.mem_write      = (state == WRITE);
  assign bus.resp_valid     = (state == RESP);
  assign bus.resp_rdata     = rdata_q;
  assign bus.mem_write_data = mwdata_q;
  assign bus.mem_address    = {2'b00, addr_q[ADDR_WIDTH-1:2]};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_fault)                         state_nx = RESP;
          else if (bus.req_write && bus.req_size[1]) state_nx = WRITE;
          else                                   state_nx = READ;
        end
      end
      READ:    state_nx = write_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Halfword lane uses addr[1] only, so a stray addr[0] is ignored when untrapped.
  always_comb begin
    byte_v = bus.mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    half_v = bus.mem_read_data[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{16{~uns_q & half_v[15]}}, half_v};
      default: load_val = bus.mem_read_data;
    endcase
    merged = bus.mem_read_data;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= bus.req_addr;
        size_q  <= bus.req_size;
        write_q <= bus.req_write;
        uns_q   <= bus.req_unsigned;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
        err_q   <= req_fault;
`endif
        // Word stores skip READ, so their write word is loaded straight away.
        if (bus.req_write && bus.req_size[1] && !req_fault)
          mwdata_q <= bus.req_wdata;
      end
      if (state == READ) begin
        if (write_q) mwdata_q <= merged;
        else         rdata_q  <= load_val;
      end
    end
  end

endmodule
